ib_acc_seq: RTL and testbench
=============================

IB_ACC_SEQ -- requirements
Module: ib_acc_seq

Interface
REQ-001 Parameter W, default 4: accumulator, operand and result width in bits.
REQ-002 CLK  input  1  single clock; all state updates on its rising edge.
REQ-003 nRST  input  1  reset, asynchronous, active-low.
REQ-004 Cmd_Valid  input  1  command present.
REQ-005 Cmd_Ready  output  1  block can accept a command.
REQ-006 Cmd_Op  input  3  opcode.
REQ-007 Cmd_Data  input  W  operand.
REQ-008 Res_Valid  output  1  result present.
REQ-009 Res_Ready  input  1  consumer accepts the result.
REQ-010 Res_Data  output  W  accumulator value.
REQ-011 Res_Carry  output  1  carry flag; for subtract, 1 = no borrow.
REQ-012 Res_Zero  output  1  set when Res_Data equals 0.
REQ-013 Res_Err  output  1  set when the last command was illegal.

Function
REQ-014 A command transfers when Cmd_Valid and Cmd_Ready are both high on a rising edge; a result transfers when Res_Valid and Res_Ready are both high on a rising edge.
REQ-015 The FSM SHALL have states IDLE, MUL and OUT; Cmd_Ready is high only in IDLE; Res_Valid is high only in OUT.
REQ-016 Transitions: IDLE to OUT on a single-cycle command; IDLE to MUL on opcode MUL; MUL to OUT after exactly W iterations; OUT to IDLE on result transfer; every other case holds the current state.
REQ-017 Opcodes:
- 000 LD: ACC = D, C = 0.
- 001 ADD: ACC = ACC + D.
- 010 SUB: ACC = ACC + ~D + 1.
- 011 ADC: ACC = ACC + D + C.
- 100 SBC: ACC = ACC + ~D + C.
- 101 MUL: ACC = low W bits of ACC*D; C = OR of the high W bits.
- 110 CLR: ACC = 0, C = 0.
- 111: illegal.
REQ-018 Arithmetic is W+1 bits wide; C = bit W of the sum; ACC = bits W-1..0.
REQ-019 Latency from command transfer to Res_Valid high: 1 cycle for single-cycle opcodes; W+1 cycles for MUL.
REQ-020 MUL SHALL be shift-and-add: one partial-product step per cycle, using a W-bit adder shared with ADD/SUB/ADC/SBC.
REQ-021 Res_Data, Res_Carry, Res_Zero and Res_Err SHALL stay stable while Res_Valid is high and Res_Ready is low.
REQ-022 Illegal opcode: ACC and C unchanged; Res_Err = 1; latency 1. Any legal command clears Res_Err.
REQ-023 Cmd_Valid asserted during MUL or OUT SHALL be ignored, with no effect on state.
REQ-024 ACC and C persist between commands.
REQ-025 Res_Ready high in the same cycle that Res_Valid first rises: the result transfers on that edge, and Cmd_Ready is high on the next cycle.

Reset
REQ-026 While nRST is low: state = IDLE; ACC, C and the MUL iteration counter = 0; Res_Valid = 0; Res_Err = 0; Res_Zero = 1; Cmd_Ready = 0.
REQ-027 Cmd_Ready SHALL rise on the first clock edge after nRST is released.
REQ-028 Reset asserted during MUL or OUT SHALL abandon the operation immediately, and no result is delivered.

Configuration
REQ-029 Macro IB_ACC_MUL_EN:
- Defined: MUL (101) operates as specified above.
- Undefined: 101 is treated as illegal per REQ-022; the MUL state and the iteration counter are not synthesised.

Structure
REQ-030 Shared package ib_acc_pkg SHALL hold the opcode enumeration, the FSM state enumeration and the default W constant.
REQ-031 The W-bit add/subtract datapath SHALL be a single sub-module, ib_addsub, with inputs B, A, AddSub and Cin, and outputs Sum and Cout.

Verification
REQ-032 Reset, then LD 9 -> Res_Data 9, C 0, Z 0, Err 0, Res_Valid one cycle after the command transfer.
REQ-033 LD 9, then ADD 9 -> Res_Data 2, C 1; next ADC 0 -> Res_Data 3, C 0.
REQ-034 LD 3, SUB 5 -> Res_Data 14, C 0; LD 5, SUB 5 -> Res_Data 0, C 1, Z 1.
REQ-035 LD 7, MUL 3 -> Res_Data 5, C 1, Res_Valid exactly 5 cycles after the command transfer; Cmd_Valid pulsed during MUL is ignored.
REQ-036 Opcode 111 after LD 6 -> Res_Data 6, Err 1; Res_Ready held low 3 cycles -> all outputs stable, Cmd_Ready 0.
REQ-037 nRST pulsed low mid-MUL -> Res_Valid 0, ACC 0, Z 1; Cmd_Ready high one edge after release.

Source files
------------

// File: rtl/ib_acc_pkg.sv
// Shared types for the ib_acc_seq accumulator: opcodes, FSM states, default width.
// The MUL state only exists when IB_ACC_MUL_EN is defined.
package ib_acc_pkg;

   localparam int ACC_W = 4;

   typedef enum logic [2:0] {
      OP_LD  = 3'b000,
      OP_ADD = 3'b001,
      OP_SUB = 3'b010,
      OP_ADC = 3'b011,
      OP_SBC = 3'b100,
      OP_MUL = 3'b101,
      OP_CLR = 3'b110,
      OP_ILL = 3'b111
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
`ifdef IB_ACC_MUL_EN
      S_MUL  = 2'd1,
`endif
      S_OUT  = 2'd2
   } state_e;

endpackage

// File: rtl/ib_addsub.sv
// W-bit add/subtract datapath: Sum/Cout = A + (AddSub ? ~B : B) + Cin.
// Shared by ADD/SUB/ADC/SBC and the MUL partial-product step.
module ib_addsub
   import ib_acc_pkg::*;
#(
   parameter int W = ACC_W
) (
   input  logic [W-1:0] B,
   input  logic [W-1:0] A,
   input  logic         AddSub,
   input  logic         Cin,
   output logic [W-1:0] Sum,
   output logic         Cout
);

   logic [W-1:0] b_eff;

   assign b_eff       = AddSub ? ~B : B;
   assign {Cout, Sum} = {1'b0, A} + {1'b0, b_eff} + {{W{1'b0}}, Cin};

endmodule

// File: rtl/ib_acc_seq.sv
// Handshaked accumulator with carry/zero/error flags and optional shift-and-add MUL.
// Define IB_ACC_MUL_EN to build MUL (opcode 101); otherwise it is an illegal opcode.
module ib_acc_seq
   import ib_acc_pkg::*;
#(
   parameter int W = ACC_W
) (
   input  logic         CLK,
   input  logic         nRST,
   input  logic         Cmd_Valid,
   output logic         Cmd_Ready,
   input  logic [2:0]   Cmd_Op,
   input  logic [W-1:0] Cmd_Data,
   output logic         Res_Valid,
   input  logic         Res_Ready,
   output logic [W-1:0] Res_Data,
   output logic         Res_Carry,
   output logic         Res_Zero,
   output logic         Res_Err
);

   state_e       state, state_nxt;
   op_e          op;
   logic         rst_done;
   logic         cmd_xfer;
   logic [W-1:0] acc;
   logic         carry;
   logic         err;
   logic [W-1:0] add_a, add_b, add_sum;
   logic         add_sub, add_cin, add_cout;
`ifdef IB_ACC_MUL_EN
   localparam int CNT_W = $clog2(W + 1);
   logic [W-1:0]     mcand;
   logic [W-1:0]     hi;
   logic [CNT_W-1:0] cnt;
   logic             mul_last;

   assign mul_last = (cnt == CNT_W'(W - 1));
`endif

   assign op        = op_e'(Cmd_Op);
   // Ready is held off until the first edge after reset release
   assign Cmd_Ready = (state == S_IDLE) && rst_done;
   assign Res_Valid = (state == S_OUT);
   assign cmd_xfer  = Cmd_Valid && Cmd_Ready;

   assign Res_Data  = acc;
   assign Res_Carry = carry;
   assign Res_Zero  = (acc == '0);
   assign Res_Err   = err;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state    <= S_IDLE;
         rst_done <= 1'b0;
      end else begin
         state    <= state_nxt;
         rst_done <= 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (cmd_xfer) begin
               state_nxt = S_OUT;
`ifdef IB_ACC_MUL_EN
               if (op == OP_MUL) state_nxt = S_MUL;
`endif
            end
         end
`ifdef IB_ACC_MUL_EN
         S_MUL: begin
            if (mul_last) state_nxt = S_OUT;
         end
`endif
         S_OUT: begin
            if (Res_Ready) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // During MUL the adder accumulates the multiplicand into the high half
   always_comb begin
      add_a   = acc;
      add_b   = Cmd_Data;
      add_sub = 1'b0;
      add_cin = 1'b0;
      case (op)
         OP_SUB: begin
            add_sub = 1'b1;
            add_cin = 1'b1;
         end
         OP_ADC: add_cin = carry;
         OP_SBC: begin
            add_sub = 1'b1;
            add_cin = carry;
         end
         default: ;
      endcase
`ifdef IB_ACC_MUL_EN
      if (state == S_MUL) begin
         add_a   = hi;
         add_b   = acc[0] ? mcand : '0;
         add_sub = 1'b0;
         add_cin = 1'b0;
      end
`endif
   end

   ib_addsub #(.W(W)) u_addsub (
      .B      (add_b),
      .A      (add_a),
      .AddSub (add_sub),
      .Cin    (add_cin),
      .Sum    (add_sum),
      .Cout   (add_cout)
   );

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         acc   <= '0;
         carry <= 1'b0;
         err   <= 1'b0;
`ifdef IB_ACC_MUL_EN
         mcand <= '0;
         hi    <= '0;
         cnt   <= '0;
`endif
      end else begin
         if (cmd_xfer) begin
            err <= 1'b0;
            case (op)
               OP_LD: begin
                  acc   <= Cmd_Data;
                  carry <= 1'b0;
               end
               OP_ADD, OP_SUB, OP_ADC, OP_SBC: begin
                  acc   <= add_sum;
                  carry <= add_cout;
               end
               OP_CLR: begin
                  acc   <= '0;
                  carry <= 1'b0;
               end
`ifdef IB_ACC_MUL_EN
               OP_MUL: begin
                  mcand <= acc;
                  acc   <= Cmd_Data;
                  hi    <= '0;
                  cnt   <= '0;
               end
`endif
               default: err <= 1'b1;
            endcase
         end
`ifdef IB_ACC_MUL_EN
         // acc holds the multiplier and shifts out as product bits shift in
         if (state == S_MUL) begin
            {hi, acc} <= {add_cout, add_sum, acc[W-1:1]};
            cnt       <= cnt + 1'b1;
            if (mul_last) carry <= |{add_cout, add_sum[W-1:1]};
         end
`endif
      end
   end

endmodule

// File: tb/tb_ib_acc_seq.sv
// Directed self-checking bench for ib_acc_seq (W=4); MUL cases depend on IB_ACC_MUL_EN.
module tb_ib_acc_seq;
   import ib_acc_pkg::*;

   logic       CLK;
   logic       nRST;
   logic       Cmd_Valid;
   logic       Cmd_Ready;
   logic [2:0] Cmd_Op;
   logic [3:0] Cmd_Data;
   logic       Res_Valid;
   logic       Res_Ready;
   logic [3:0] Res_Data;
   logic       Res_Carry;
   logic       Res_Zero;
   logic       Res_Err;

   int n_chk  = 0;
   int n_fail = 0;
   int lat;

   ib_acc_seq #(.W(4)) dut (
      .CLK       (CLK),
      .nRST      (nRST),
      .Cmd_Valid (Cmd_Valid),
      .Cmd_Ready (Cmd_Ready),
      .Cmd_Op    (Cmd_Op),
      .Cmd_Data  (Cmd_Data),
      .Res_Valid (Res_Valid),
      .Res_Ready (Res_Ready),
      .Res_Data  (Res_Data),
      .Res_Carry (Res_Carry),
      .Res_Zero  (Res_Zero),
      .Res_Err   (Res_Err)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_res(input string tag, input int d, input int c, input int z, input int e);
      check({tag, ".data"},  Res_Data,  d);
      check({tag, ".carry"}, Res_Carry, c);
      check({tag, ".zero"},  Res_Zero,  z);
      check({tag, ".err"},   Res_Err,   e);
   endtask

   // Transfers one command and returns cycles until Res_Valid is seen (1 = next cycle).
   task automatic send(input logic [2:0] op, input logic [3:0] d, input bit noise, output int l);
      int n;
      n = 0;
      while (!Cmd_Ready && n < 20) begin
         @(posedge CLK); #1;
         n++;
      end
      if (!Cmd_Ready) check("cmd_ready_wait", 0, 1);
      Cmd_Valid = 1'b1;
      Cmd_Op    = op;
      Cmd_Data  = d;
      @(posedge CLK); #1;
      Cmd_Valid = noise;
      Cmd_Op    = OP_LD;
      Cmd_Data  = 4'hF;
      l = 1;
      while (!Res_Valid && l < 20) begin
         @(posedge CLK); #1;
         l++;
      end
      Cmd_Valid = 1'b0;
   endtask

   task automatic accept(input string tag);
      Res_Ready = 1'b1;
      @(posedge CLK); #1;
      Res_Ready = 1'b0;
      check({tag, ".vld_after"}, Res_Valid, 0);
      check({tag, ".rdy_after"}, Cmd_Ready, 1);
   endtask

   initial begin
      nRST      = 1'b0;
      Cmd_Valid = 1'b0;
      Cmd_Op    = 3'b000;
      Cmd_Data  = 4'h0;
      Res_Ready = 1'b0;

      repeat (3) @(posedge CLK);
      #1;
      check("rst.cmd_ready", Cmd_Ready, 0);
      check("rst.res_valid", Res_Valid, 0);
      chk_res("rst", 0, 0, 1, 0);
      @(negedge CLK);
      nRST = 1'b1;
      #1;
      check("rel.cmd_ready_before_edge", Cmd_Ready, 0);
      @(posedge CLK); #1;
      check("rel.cmd_ready_after_edge", Cmd_Ready, 1);

      send(OP_LD, 4'd9, 1'b0, lat);
      check("ld9.lat", lat, 1);
      check("ld9.cmd_ready", Cmd_Ready, 0);
      chk_res("ld9", 9, 0, 0, 0);
      accept("ld9");

      send(OP_ADD, 4'd9, 1'b0, lat);
      check("add9.lat", lat, 1);
      chk_res("add9", 2, 1, 0, 0);
      accept("add9");
      send(OP_ADC, 4'd0, 1'b0, lat);
      chk_res("adc0", 3, 0, 0, 0);
      accept("adc0");

      send(OP_LD, 4'd3, 1'b0, lat);
      accept("ld3");
      send(OP_SUB, 4'd5, 1'b0, lat);
      chk_res("sub5a", 14, 0, 0, 0);
      accept("sub5a");
      send(OP_LD, 4'd5, 1'b0, lat);
      accept("ld5");
      send(OP_SUB, 4'd5, 1'b0, lat);
      chk_res("sub5b", 0, 1, 1, 0);
      accept("sub5b");

      // 0 + ~1 + 1 = 15 no carry, then 15 + ~1 + 0 = 29 -> 13 carry
      send(OP_SBC, 4'd1, 1'b0, lat);
      chk_res("sbc1a", 15, 0, 0, 0);
      accept("sbc1a");
      send(OP_SBC, 4'd1, 1'b0, lat);
      chk_res("sbc1b", 13, 1, 0, 0);
      accept("sbc1b");

      send(OP_CLR, 4'd7, 1'b0, lat);
      chk_res("clr", 0, 0, 1, 0);
      accept("clr");

      send(OP_LD, 4'd6, 1'b0, lat);
      accept("ld6");
      send(3'b111, 4'd2, 1'b0, lat);
      check("ill.lat", lat, 1);
      for (int i = 0; i < 3; i++) begin
         check("ill.hold_valid", Res_Valid, 1);
         check("ill.hold_ready", Cmd_Ready, 0);
         chk_res("ill.hold", 6, 0, 0, 1);
         @(posedge CLK); #1;
      end
      accept("ill");
      send(OP_LD, 4'd1, 1'b0, lat);
      chk_res("err_clear", 1, 0, 0, 0);
      accept("err_clear");

      send(OP_LD, 4'd7, 1'b0, lat);
      accept("ld7");
`ifdef IB_ACC_MUL_EN
      send(OP_MUL, 4'd3, 1'b1, lat);
      check("mul.lat", lat, 5);
      chk_res("mul", 5, 1, 0, 0);
`else
      send(OP_MUL, 4'd3, 1'b0, lat);
      check("mul_ill.lat", lat, 1);
      chk_res("mul_ill", 7, 0, 0, 1);
`endif
      accept("mul");

      // Reset while an operation is in flight
      send(OP_LD, 4'd7, 1'b0, lat);
      accept("ld7b");
      Cmd_Valid = 1'b1;
`ifdef IB_ACC_MUL_EN
      Cmd_Op    = OP_MUL;
`else
      Cmd_Op    = OP_LD;
`endif
      Cmd_Data  = 4'd3;
      @(posedge CLK); #1;
      Cmd_Valid = 1'b0;
      @(posedge CLK);
      @(negedge CLK);
      nRST = 1'b0;
      #1;
      check("midrst.res_valid", Res_Valid, 0);
      check("midrst.cmd_ready", Cmd_Ready, 0);
      chk_res("midrst", 0, 0, 1, 0);
      @(posedge CLK);
      @(negedge CLK);
      nRST = 1'b1;
      #1;
      check("midrst.ready_before_edge", Cmd_Ready, 0);
      @(posedge CLK); #1;
      check("midrst.ready_after_edge", Cmd_Ready, 1);
      repeat (6) @(posedge CLK);
      #1;
      check("midrst.no_result", Res_Valid, 0);
      check("midrst.acc", Res_Data, 0);

      // Consumer already ready when the result appears
      Res_Ready = 1'b1;
      send(OP_LD, 4'd4, 1'b0, lat);
      check("early.lat", lat, 1);
      chk_res("early", 4, 0, 0, 0);
      @(posedge CLK); #1;
      check("early.vld_after", Res_Valid, 0);
      check("early.rdy_after", Cmd_Ready, 1);
      Res_Ready = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
